// File: rtl/data_mem_unit_pkg.sv
// Shared load/store definitions: access length codes, FSM states, alignment helper.
package mem_defs;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned LEN_W  = 2;

   localparam logic [LEN_W-1:0] LEN_NONE = 2'b00;
   localparam logic [LEN_W-1:0] LEN_BYTE = 2'b01;
   localparam logic [LEN_W-1:0] LEN_HALF = 2'b10;
   localparam logic [LEN_W-1:0] LEN_WORD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_READ = 2'b01,
      S_RESP = 2'b10
   } state_t;

   // Half needs addr[0]==0, word needs addr[1:0]==00.
   function automatic logic is_misaligned(input logic [LEN_W-1:0] len, input logic [1:0] off);
      return ((len == LEN_HALF) && off[0]) || ((len == LEN_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Lane-select a RAM word and sign/zero-extend it to 32 bits (combinational).
module mem_load_extend
   import mem_defs::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [1:0]        offset,
   input  logic [LEN_W-1:0]  mem_length,
   input  logic              mem_signed,
   output logic [WORD_W-1:0] rdata_c
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Pick the addressed byte/half, then extend according to access length.
   always_comb begin
      lane_b  = word[7:0];
      lane_h  = offset[1] ? word[31:16] : word[15:0];
      rdata_c = '0;
      case (offset)
         2'd0:    lane_b = word[7:0];
         2'd1:    lane_b = word[15:8];
         2'd2:    lane_b = word[23:16];
         default: lane_b = word[31:24];
      endcase
      case (mem_length)
         LEN_BYTE: rdata_c = {{24{mem_signed & lane_b[7]}}, lane_b};
         LEN_HALF: rdata_c = {{16{mem_signed & lane_h[15]}}, lane_h};
         LEN_WORD: rdata_c = word;
         default:  rdata_c = '0;
      endcase
   end

endmodule

// File: rtl/data_mem_unit.sv
// Load/store responder over a word-organised synchronous RAM with valid/ready handshake.
// Optional MEM_ALIGN_CHECK_EN: reject misaligned accesses with misalign=1 instead of
// forcing the low address bits to alignment.
module data_mem_unit
   import mem_defs::*;
#(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              memread,
   input  logic              memwrite,
   input  logic [LEN_W-1:0]  mem_length,
   input  logic              mem_signed,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic              resp_valid,
   output logic [WORD_W-1:0] rdata,
   output logic              misalign
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   state_t                  state, state_nxt;
   logic [WORD_W-1:0]       ram [DEPTH];
   logic [DEPTH_LOG2-1:0]   widx;
   logic                    accept, is_store, is_load, mis_c;
   logic                    do_write, do_read;
   logic [1:0]              off_c;
   logic [3:0]              be_c;
   logic [WORD_W-1:0]       wd_c;
   logic [WORD_W-1:0]       rd_word, ext_c;
   logic [1:0]              ld_off;
   logic [LEN_W-1:0]        ld_len;
   logic                    ld_signed;
   logic                    unused_addr_hi;

   assign req_ready      = (state == S_IDLE) && !rst;
   assign accept         = req_valid && req_ready;
   assign widx           = addr[DEPTH_LOG2+1:2];
   assign unused_addr_hi = ^addr[WORD_W-1:DEPTH_LOG2+2];

   // Decode the request, build lane enables and steer the FSM.
   always_comb begin
      state_nxt = state;
      do_write  = 1'b0;
      do_read   = 1'b0;
      off_c     = addr[1:0];
      be_c      = '0;
      wd_c      = wdata;
      mis_c     = 1'b0;
      is_store  = memwrite && (mem_length != LEN_NONE);
      is_load   = memread && !memwrite && (mem_length != LEN_NONE);
`ifdef MEM_ALIGN_CHECK_EN
      mis_c = (is_store || is_load) && is_misaligned(mem_length, addr[1:0]);
`else
      if (mem_length == LEN_HALF) begin
         off_c[0] = 1'b0;
      end else if (mem_length == LEN_WORD) begin
         off_c = 2'b00;
      end
`endif
      case (mem_length)
         LEN_BYTE: begin
            be_c = 4'b0001 << off_c;
            wd_c = {4{wdata[7:0]}};
         end
         LEN_HALF: begin
            be_c = off_c[1] ? 4'b1100 : 4'b0011;
            wd_c = {2{wdata[15:0]}};
         end
         LEN_WORD: be_c = 4'b1111;
         default:  be_c = 4'b0000;
      endcase
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (is_load && !mis_c) begin
                  do_read   = 1'b1;
                  state_nxt = S_READ;
               end else begin
                  do_write  = is_store && !mis_c;
                  state_nxt = S_RESP;
               end
            end
         end
         S_READ:  state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // RAM port: lane-masked write or word read plus load attribute capture on accept.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) begin
               ram[widx][8*i +: 8] <= wd_c[8*i +: 8];
            end
         end
      end
      if (do_read) begin
         rd_word   <= ram[widx];
         ld_off    <= off_c;
         ld_len    <= mem_length;
         ld_signed <= mem_signed;
      end
   end

   mem_load_extend u_load_extend (
      .word       (rd_word),
      .offset     (ld_off),
      .mem_length (ld_len),
      .mem_signed (ld_signed),
      .rdata_c    (ext_c)
   );

   // Response registers: one-cycle resp_valid in RESP, rdata/misalign held between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         rdata      <= '0;
         misalign   <= 1'b0;
      end else begin
         resp_valid <= (state_nxt == S_RESP);
         if ((state == S_IDLE) && accept && !do_read) begin
            rdata    <= '0;
            misalign <= mis_c;
         end else if (state == S_READ) begin
            rdata    <= ext_c;
            misalign <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: directed vector table, handshake/reset
// sequences, and randomized traffic against a byte-addressed reference memory.
module tb_data_mem_unit;

   localparam int unsigned DL2    = 10;
   localparam int unsigned NBYTES = 4 << DL2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic        memread, memwrite, mem_signed;
   logic [1:0]  mem_length;
   logic [31:0] addr, wdata;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        misalign;

   int checks = 0;
   int errors = 0;

   logic [7:0] ref_mem [NBYTES];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  len;
      logic        sg;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] er;
      logic        em;
      int          el;
   } vec_t;

   vec_t vecs[$];

   data_mem_unit #(.DEPTH_LOG2(DL2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .memread    (memread),
      .memwrite   (memwrite),
      .mem_length (mem_length),
      .mem_signed (mem_signed),
      .addr       (addr),
      .wdata      (wdata),
      .resp_valid (resp_valid),
      .rdata      (rdata),
      .misalign   (misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] len,
                               input logic sg, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] er, input logic em, input int el);
      vec_t v;
      v.rd = rd; v.wr = wr; v.len = len; v.sg = sg; v.a = a; v.wd = wd;
      v.er = er; v.em = em; v.el = el;
      return v;
   endfunction

   // Reference behaviour over a flat byte array; returns expected rdata, misalign, latency.
   task automatic model(input logic rd, input logic wr, input logic [1:0] len, input logic sg,
                        input logic [31:0] a_in, input logic [31:0] wd,
                        output logic [31:0] er, output logic em, output int el);
      int unsigned a, size;
      logic        st, ld, mis;
      logic [31:0] v;
      a    = a_in % NBYTES;
      size = (len == 2'd0) ? 0 : (len == 2'd1) ? 1 : (len == 2'd2) ? 2 : 4;
      st   = wr && (size != 0);
      ld   = rd && !wr && (size != 0);
      mis  = (st || ld) && (size > 1) && ((a % size) != 0);
      er = '0; em = 1'b0; el = 1;
`ifdef MEM_ALIGN_CHECK_EN
      if (mis) begin
         em = 1'b1;
         return;
      end
`else
      if (mis) a = a - (a % size);
`endif
      if (st) begin
         for (int i = 0; i < int'(size); i++) ref_mem[a + i] = wd[8*i +: 8];
      end else if (ld) begin
         v = '0;
         for (int i = 0; i < int'(size); i++) v = v | (32'(ref_mem[a + i]) << (8*i));
         if (sg && (size < 4) && v[8*size-1]) v = v | (~32'h0 << (8*size));
         er = v;
         el = 2;
      end
   endtask

   // Issue one request, wait for accept, then time the response (bounded).
   task automatic transact(input logic rd, input logic wr, input logic [1:0] len, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] gr, output logic gm, output int lat);
      int n;
      @(negedge clk);
      memread = rd; memwrite = wr; mem_length = len; mem_signed = sg;
      addr = a; wdata = wd; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      memread    = 1'($urandom);
      memwrite   = 1'($urandom);
      mem_length = 2'($urandom);
      mem_signed = 1'($urandom);
      addr       = $urandom;
      wdata      = $urandom;
      lat = 0; gr = 'x; gm = 1'bx;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = k; gr = rdata; gm = misalign;
            break;
         end
      end
   endtask

   // Run one access, compare against expectations, and check pulse width and data hold.
   task automatic run_check(input string name, input logic rd, input logic wr, input logic [1:0] len,
                            input logic sg, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] er, input logic em, input int el);
      logic [31:0] gr;
      logic        gm;
      int          lat;
      transact(rd, wr, len, sg, a, wd, gr, gm, lat);
      check({name, "_lat"}, 32'(lat), 32'(el));
      check({name, "_rdata"}, gr, er);
      check({name, "_mis"}, 32'(gm), 32'(em));
      @(negedge clk);
      check({name, "_pulse"}, 32'(resp_valid), 32'd0);
      check({name, "_hold"}, rdata, er);
   endtask

   initial begin
      logic [31:0] er, exp_w;
      logic        em;
      int          el, acc, resp, low;
      logic        rr, ww, ss;
      logic [1:0]  ll;
      logic [31:0] aa, dd;

      rst = 1'b1; req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
      mem_length = 2'b00; mem_signed = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_misalign", 32'(misalign), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(req_ready), 32'd1);

      // Preload words 0..63 so every later load reads defined data.
      for (int w = 0; w < 64; w++) begin
         dd = $urandom;
         model(1'b0, 1'b1, 2'b11, 1'b0, 32'(w * 4), dd, er, em, el);
         run_check("preload", 1'b0, 1'b1, 2'b11, 1'b0, 32'(w * 4), dd, er, em, el);
      end

      vecs.push_back(mk(0, 1, 2'b11, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1));
      vecs.push_back(mk(1, 0, 2'b11, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2));
      vecs.push_back(mk(0, 1, 2'b01, 0, 32'h12, 32'h12345680, 32'h0, 0, 1));
      vecs.push_back(mk(1, 0, 2'b11, 0, 32'h10, 32'h0, 32'hDE80BEEF, 0, 2));
      vecs.push_back(mk(1, 0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFFFF80, 0, 2));
      vecs.push_back(mk(1, 0, 2'b01, 0, 32'h12, 32'h0, 32'h00000080, 0, 2));
      vecs.push_back(mk(0, 1, 2'b11, 0, 32'h20, 32'h5555AAAA, 32'h0, 0, 1));
      vecs.push_back(mk(0, 1, 2'b10, 0, 32'h22, 32'hABCD8001, 32'h0, 0, 1));
      vecs.push_back(mk(1, 0, 2'b10, 1, 32'h22, 32'h0, 32'hFFFF8001, 0, 2));
      vecs.push_back(mk(1, 0, 2'b10, 0, 32'h22, 32'h0, 32'h00008001, 0, 2));
      vecs.push_back(mk(1, 0, 2'b11, 0, 32'h20, 32'h0, 32'h8001AAAA, 0, 2));
`ifdef MEM_ALIGN_CHECK_EN
      vecs.push_back(mk(1, 0, 2'b11, 0, 32'h13, 32'h0, 32'h0, 1, 1));
      vecs.push_back(mk(0, 1, 2'b11, 0, 32'h13, 32'h11111111, 32'h0, 1, 1));
      vecs.push_back(mk(1, 0, 2'b11, 0, 32'h10, 32'h0, 32'hDE80BEEF, 0, 2));
`else
      vecs.push_back(mk(1, 0, 2'b11, 0, 32'h13, 32'h0, 32'hDE80BEEF, 0, 2));
      vecs.push_back(mk(0, 1, 2'b11, 0, 32'h13, 32'h11111111, 32'h0, 0, 1));
      vecs.push_back(mk(1, 0, 2'b11, 0, 32'h10, 32'h0, 32'h11111111, 0, 2));
`endif
      vecs.push_back(mk(0, 1, 2'b11, 0, 32'h1004, 32'h12345678, 32'h0, 0, 1));
      vecs.push_back(mk(1, 0, 2'b11, 0, 32'h4, 32'h0, 32'h12345678, 0, 2));
      vecs.push_back(mk(1, 0, 2'b00, 0, 32'h10, 32'h0, 32'h0, 0, 1));
      vecs.push_back(mk(0, 0, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 32'h0, 0, 1));
`ifdef MEM_ALIGN_CHECK_EN
      vecs.push_back(mk(1, 0, 2'b11, 0, 32'h10, 32'h0, 32'hDE80BEEF, 0, 2));
      vecs.push_back(mk(1, 0, 2'b10, 1, 32'h21, 32'h0, 32'h0, 1, 1));
`else
      vecs.push_back(mk(1, 0, 2'b11, 0, 32'h10, 32'h0, 32'h11111111, 0, 2));
      vecs.push_back(mk(1, 0, 2'b10, 1, 32'h21, 32'h0, 32'hFFFFAAAA, 0, 2));
`endif
      vecs.push_back(mk(1, 1, 2'b11, 0, 32'h24, 32'hCAFEF00D, 32'h0, 0, 1));
      vecs.push_back(mk(1, 0, 2'b11, 0, 32'h24, 32'h0, 32'hCAFEF00D, 0, 2));

      foreach (vecs[i]) begin
         model(vecs[i].rd, vecs[i].wr, vecs[i].len, vecs[i].sg, vecs[i].a, vecs[i].wd, er, em, el);
         run_check($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].len, vecs[i].sg,
                   vecs[i].a, vecs[i].wd, vecs[i].er, vecs[i].em, vecs[i].el);
      end

      // req_valid held high across back-to-back loads.
      model(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, exp_w, em, el);
      @(negedge clk);
      memread = 1'b1; memwrite = 1'b0; mem_length = 2'b11; mem_signed = 1'b0;
      addr = 32'h20; req_valid = 1'b1;
      acc = 0; resp = 0; low = 0;
      for (int i = 0; i < 12; i++) begin
         if (req_ready) acc++;
         else low++;
         @(negedge clk);
         if (resp_valid) begin
            resp++;
            check("held_rdata", rdata, exp_w);
         end
      end
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (resp_valid) resp++;
      end
      check("held_accepts", 32'(acc), 32'd4);
      check("held_resps", 32'(resp), 32'd4);
      check("held_ready_low", 32'(low), 32'd8);

      // Reset during READ abandons the load.
      @(negedge clk);
      memread = 1'b1; memwrite = 1'b0; mem_length = 2'b11; addr = 32'h10; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("read_ready_low", 32'(req_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_read_no_resp", 32'(resp_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_read_ready", 32'(req_ready), 32'd1);
      check("rst_read_rdata", rdata, 32'd0);
      resp = 0;
      for (int i = 0; i < 3; i++) begin
         if (resp_valid) resp++;
         @(negedge clk);
      end
      check("rst_read_resps", 32'(resp), 32'd0);

      // Store committed before a reset in RESP survives.
      model(1'b0, 1'b1, 2'b11, 1'b0, 32'h30, 32'h0BADF00D, er, em, el);
      @(negedge clk);
      memread = 1'b0; memwrite = 1'b1; mem_length = 2'b11; addr = 32'h30;
      wdata = 32'h0BADF00D; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_resp_cleared", 32'(resp_valid), 32'd0);
      rst = 1'b0;
      model(1'b1, 1'b0, 2'b11, 1'b0, 32'h30, 32'h0, er, em, el);
      run_check("store_survives", 1'b1, 1'b0, 2'b11, 1'b0, 32'h30, 32'h0, er, em, el);

      // Randomized traffic over words 0..63 with random high address bits.
      for (int i = 0; i < 300; i++) begin
         rr = 1'($urandom);
         ww = ($urandom_range(0, 2) == 0);
         ll = 2'($urandom);
         ss = 1'($urandom);
         aa = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
         dd = $urandom;
         model(rr, ww, ll, ss, aa, dd, er, em, el);
         run_check("rand", rr, ww, ll, ss, aa, dd, er, em, el);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
Responder end of the load/store control interface driven by the instruction decoder.
- Consumes memread, memwrite, mem_length and mem_signed, plus the ALU-computed address and store data.
- Performs byte, half-word and word accesses on an internal word-organised synchronous RAM.
- Returns sign- or zero-extended load data to the writeback mux through a valid/ready request and response handshake.

Parameters:
DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (default 1024 words, 4 KiB).

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  synchronous reset, active-high.
req_valid  input  1  request present this cycle.
req_ready  output  1  unit can accept a request this cycle.
memread  input  1  load request.
memwrite  input  1  store request.
mem_length  input  2  00 none, 01 byte, 10 half, 11 word.
mem_signed  input  1  1 = sign-extend load data, 0 = zero-extend.
addr  input  32  byte address.
wdata  input  32  store data, right-aligned.
resp_valid  output  1  one-cycle pulse: request completed.
rdata  output  32  extended load data; registered; held until the next response.
misalign  output  1  completed request was misaligned; registered with rdata.

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-high reset, rst.
- Reset values: state IDLE, req_ready 0 while rst is high and 1 after, resp_valid 0, rdata 0, misalign 0. RAM contents are not reset.
- States: IDLE, READ, RESP.
- Accept: a request is accepted when req_valid && req_ready. req_ready = (state==IDLE) && !rst.
- IDLE, store accepted (memwrite=1, mem_length!=00):
  - Byte lanes are written on the accept edge.
  - Next state RESP.
  - rdata is set to 0.
- IDLE, load accepted (memread=1, memwrite=0, mem_length!=00):
  - The RAM word is read on the accept edge.
  - Captured at the same edge: byte offset, mem_length, mem_signed.
  - Next state READ.
- IDLE, null request accepted (mem_length==00, or neither memread nor memwrite): no RAM action, rdata 0, next state RESP.
- memread and memwrite both 1: treated as a store; memread is ignored.
- READ: lane-select and extend the RAM output word, register it into rdata, next state RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency from accept to resp_valid: 1 cycle for stores and null requests, 2 cycles for loads.
- Back-to-back: a new request can be accepted in the cycle after RESP.
- Addressing:
  - Word index = addr[DEPTH_LOG2+1:2].
  - Higher address bits are ignored, so addresses wrap modulo the RAM size.
  - Little-endian.
- Store lanes:
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],1}:{addr[1],0}.
  - Word: all four lanes.
  - Unselected lanes are unchanged.
- Load extraction:
  - Byte: lane addr[1:0], extended from bit 7.
  - Half: lane pair selected by addr[1], extended from bit 15.
  - Word: no extension; mem_signed is ignored.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=00. Handling is set by the optional feature below.
- Reset mid-operation:
  - A pending READ or RESP is abandoned and no resp_valid is produced.
  - A store committed before reset remains in RAM.
- Inputs are sampled only at accept; changes on them after accept have no effect.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined:
  - A misaligned request is accepted, but the RAM is neither written nor read.
  - Next state RESP, with rdata=0 and misalign=1 registered for that response.
- Undefined:
  - Low address bits are forced to alignment: half clears addr[0], word clears addr[1:0].
  - The access then proceeds normally.
  - misalign is tied to 0.

Decomposition:
- Shared header/package mem_defs:
  - LEN_NONE=2'b00, LEN_BYTE=2'b01, LEN_HALF=2'b10, LEN_WORD=2'b11.
  - State encodings S_IDLE, S_READ, S_RESP.
- One sub-module, mem_load_extend (combinational):
  - Inputs: 32-bit word, offset[1:0], mem_length, mem_signed.
  - Output: extended 32-bit rdata.
  - Instantiated in the READ path. The decoder team can reuse it elsewhere.

Test Plan:
1. Word store then load: store addr=0x10, wdata=0xDEADBEEF, mem_length=11 -> resp_valid 1 cycle after accept. Then load addr=0x10 -> resp_valid 2 cycles after accept, rdata=0xDEADBEEF.
2. Byte store merge and extension, over word 0x10=0xDEADBEEF:
   - Store byte 0x80 to addr=0x12; the word becomes 0xDE80BEEF.
   - lb addr=0x12 -> rdata=0xFFFFFF80.
   - lbu addr=0x12 -> rdata=0x00000080.
3. Half access: store half 0x8001 to addr=0x22. lh -> rdata=0xFFFF8001; lhu -> rdata=0x00008001; the low half of word 0x20 is unchanged.
4. Misaligned lw addr=0x13:
   - With MEM_ALIGN_CHECK_EN: misalign=1, rdata=0, and word 0x10 is not modified by a misaligned sw.
   - Without it: reads word 0x10, misalign=0.
5. Handshake and reset:
   - req_valid held high across loads -> req_ready low in READ and RESP; exactly one resp_valid per accept.
   - rst asserted during READ -> no resp_valid, and the unit is in IDLE with req_ready=1 on the cycle after rst deasserts.
6. Wrap and null request:
   - Store to addr=(1<<(DEPTH_LOG2+2))+0x4 -> the same word is read back at addr=0x4.
   - mem_length=00 with req_valid=1 -> resp_valid after 1 cycle, rdata=0, RAM unchanged.
